// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, status codes and the pipeline control state enum.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT  = 4'h0;
  localparam logic [3:0] ICODE_NOP   = 4'h1;
  localparam logic [3:0] ICODE_MRMOV = 4'h5;
  localparam logic [3:0] ICODE_JXX   = 4'h7;
  localparam logic [3:0] ICODE_CALL  = 4'h8;
  localparam logic [3:0] ICODE_RET   = 4'h9;
  localparam logic [3:0] ICODE_POPQ  = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  localparam logic [3:0] STAT_AOK = 4'd1;
  localparam logic [3:0] STAT_HLT = 4'd2;
  localparam logic [3:0] STAT_ADR = 4'd3;
  localparam logic [3:0] STAT_INS = 4'd4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_e;

  // True for the status codes that stop the machine.
  function automatic logic is_exc_stat(input logic [3:0] stat);
    return (stat == STAT_HLT) || (stat == STAT_ADR) || (stat == STAT_INS);
  endfunction

endpackage

// File: rtl/y86_hazard_detect.sv
// Combinational hazard terms: load-use, mispredict, ret in flight, exception in M/W.
module y86_hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [3:0] M_icode,
  input  logic [3:0] m_stat,
  input  logic [3:0] W_stat,
  output logic       lu,
  output logic       mp,
  output logic       rt,
  output logic       ex
);

  always_comb begin
    lu = ((E_icode == ICODE_MRMOV) || (E_icode == ICODE_POPQ)) &&
         (E_dstM != REG_NONE) &&
         ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    mp = (E_icode == ICODE_JXX) && !e_Cnd;
    rt = (D_icode == ICODE_RET) || (E_icode == ICODE_RET) || (M_icode == ICODE_RET);
    ex = is_exc_stat(m_stat) || is_exc_stat(W_stat);
  end

endmodule

// File: rtl/pipe_ctrl_64.sv
// Y86-64 pipeline control: stall/bubble generation, run/drain/halt status FSM
// and wrapping performance counters.
module pipe_ctrl_64
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  input  logic [3:0]       W_icode,
  input  logic             dbg_freeze,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic [3:0]       cpu_stat,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] loaduse_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  logic lu, mp, rt, ex;

  y86_hazard_detect u_hazard (
    .D_icode (D_icode),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .E_icode (E_icode),
    .E_dstM  (E_dstM),
    .e_Cnd   (e_Cnd),
    .M_icode (M_icode),
    .m_stat  (m_stat),
    .W_stat  (W_stat),
    .lu      (lu),
    .mp      (mp),
    .rt      (rt),
    .ex      (ex)
  );

  pipe_state_e      state_q, state_d;
  logic [3:0]       cpu_stat_q, cpu_stat_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
  logic [CNT_W-1:0] loaduse_cnt_q, loaduse_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
  logic             adv;
  logic             retire;

  assign adv    = (state_q != HALTED) && !dbg_freeze;
  assign retire = (W_icode != ICODE_NOP) && ((W_stat == STAT_AOK) || (W_stat == STAT_HLT));

  // Stall and bubble controls; D_bubble is masked by lu so stall always wins on D.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    if (state_q == HALTED) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      W_stall  = 1'b1;
      M_bubble = 1'b1;
    end else if (dbg_freeze) begin
      F_stall = 1'b1;
      D_stall = 1'b1;
      W_stall = 1'b1;
    end else begin
      F_stall  = lu || rt;
      D_stall  = lu;
      D_bubble = mp || (rt && !lu);
      E_bubble = mp || lu;
      M_bubble = ex;
      W_stall  = (W_stat != STAT_AOK);
    end
  end

  always_comb begin
    state_d       = state_q;
    cpu_stat_d    = cpu_stat_q;
    cycle_cnt_d   = cycle_cnt_q;
    retired_cnt_d = retired_cnt_q;
    loaduse_cnt_d = loaduse_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    ret_cnt_d     = ret_cnt_q;
    if (adv) begin
      // W_stat is checked first so it wins over a simultaneous m_stat fault.
      if (W_stat != STAT_AOK) begin
        state_d    = HALTED;
        cpu_stat_d = W_stat;
      end else if ((state_q == RUN) && (m_stat != STAT_AOK)) begin
        state_d = DRAIN;
      end
      cycle_cnt_d   = cycle_cnt_q + CNT_W'(1);
      retired_cnt_d = retired_cnt_q + CNT_W'(retire);
      loaduse_cnt_d = loaduse_cnt_q + CNT_W'(lu);
      mispred_cnt_d = mispred_cnt_q + CNT_W'(mp);
      ret_cnt_d     = ret_cnt_q + CNT_W'(rt && !lu);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      cpu_stat_q    <= STAT_AOK;
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
      loaduse_cnt_q <= '0;
      mispred_cnt_q <= '0;
      ret_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      cpu_stat_q    <= cpu_stat_d;
      cycle_cnt_q   <= cycle_cnt_d;
      retired_cnt_q <= retired_cnt_d;
      loaduse_cnt_q <= loaduse_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      ret_cnt_q     <= ret_cnt_d;
    end
  end

  assign cpu_stat    = cpu_stat_q;
  assign halted      = (state_q == HALTED);
  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;
  assign loaduse_cnt = loaduse_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
  assign ret_cnt     = ret_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_64.sv
// Directed bench for pipe_ctrl_64: hazard controls, status FSM, freeze, reset and counter wrap.
module tb_pipe_ctrl_64;

  logic       clk;
  logic       rst;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat, W_icode;
  logic       e_Cnd, dbg_freeze;

  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
  logic [3:0]  cpu_stat;
  logic [31:0] cycle_cnt, retired_cnt, loaduse_cnt, mispred_cnt, ret_cnt;

  logic        w_F_stall, w_D_stall, w_D_bubble, w_E_bubble, w_M_bubble, w_W_stall, w_halted;
  logic [3:0]  w_cpu_stat;
  logic [3:0]  w_cycle_cnt, w_retired_cnt, w_loaduse_cnt, w_mispred_cnt, w_ret_cnt;

  logic [5:0]  ctl;
  int          n_chk;
  int          n_fail;

  assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};

  pipe_ctrl_64 #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode), .dbg_freeze(dbg_freeze),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .cpu_stat(cpu_stat), .halted(halted),
    .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt), .loaduse_cnt(loaduse_cnt),
    .mispred_cnt(mispred_cnt), .ret_cnt(ret_cnt)
  );

  pipe_ctrl_64 #(.CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode), .dbg_freeze(dbg_freeze),
    .F_stall(w_F_stall), .D_stall(w_D_stall), .D_bubble(w_D_bubble), .E_bubble(w_E_bubble),
    .M_bubble(w_M_bubble), .W_stall(w_W_stall), .cpu_stat(w_cpu_stat), .halted(w_halted),
    .cycle_cnt(w_cycle_cnt), .retired_cnt(w_retired_cnt), .loaduse_cnt(w_loaduse_cnt),
    .mispred_cnt(w_mispred_cnt), .ret_cnt(w_ret_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
    E_icode = 4'h1; E_dstM = 4'hF; e_Cnd = 1'b0;
    M_icode = 4'h1; m_stat = 4'd1; W_stat = 4'd1; W_icode = 4'h1;
    dbg_freeze = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    idle();
    #1;
    chk("rst_cpu_stat", cpu_stat, 4'd1);
    chk("rst_halted", halted, 1'b0);
    chk("rst_cycle", cycle_cnt, 0);
    chk("rst_ctl_idle", ctl, 6'b000000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();                                           // cycle 1

    // load-use via srcA
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    #1 chk("lu_ctl", ctl, 6'b110100);
    tick(); tick();                                   // cycle 3, lu 2
    chk("lu_cnt", loaduse_cnt, 2);
    d_srcA = 4'hF; d_srcB = 4'h3;
    #1 chk("lu_srcB_dstall", D_stall, 1'b1);
    E_dstM = 4'hF; d_srcB = 4'hF;
    #1 chk("lu_none_reg", ctl, 6'b000000);
    idle();

    // mispredict, then taken branch
    E_icode = 4'h7; e_Cnd = 1'b0;
    #1 chk("mp_ctl", ctl, 6'b001100);
    tick();                                           // cycle 4, mp 1
    e_Cnd = 1'b1;
    #1 chk("taken_ctl", ctl, 6'b000000);
    tick();                                           // cycle 5
    chk("mp_cnt", mispred_cnt, 1);
    idle();

    // ret walking through D, E, M
    D_icode = 4'h9;
    #1 chk("ret_D_ctl", ctl, 6'b101000);
    tick();                                           // cycle 6
    D_icode = 4'h1; E_icode = 4'h9;
    #1 chk("ret_E_ctl", ctl, 6'b101000);
    tick();                                           // cycle 7
    E_icode = 4'h1; M_icode = 4'h9;
    #1 chk("ret_M_ctl", ctl, 6'b101000);
    tick();                                           // cycle 8
    M_icode = 4'h1;
    chk("ret_cnt", ret_cnt, 3);

    // ret in D together with load-use: stall wins
    D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    #1 chk("ret_lu_ctl", ctl, 6'b110100);
    tick();                                           // cycle 9
    chk("ret_lu_retcnt", ret_cnt, 3);
    chk("ret_lu_lucnt", loaduse_cnt, 3);
    idle();

    // one retiring instruction
    W_icode = 4'h6;
    tick();                                           // cycle 10
    W_icode = 4'h1;
    chk("retired_one", retired_cnt, 1);

    // debug freeze with a mispredict present
    dbg_freeze = 1'b1; E_icode = 4'h7; e_Cnd = 1'b0;
    #1 chk("freeze_ctl", ctl, 6'b110001);
    repeat (5) tick();
    chk("freeze_cycle", cycle_cnt, 10);
    chk("freeze_mp", mispred_cnt, 1);
    idle();

    // ADR in memory, then reaches writeback
    m_stat = 4'd3;
    #1 chk("adr_m_ctl", ctl, 6'b000010);
    tick();                                           // cycle 11, DRAIN
    chk("drain_halted", halted, 1'b0);
    chk("drain_stat", cpu_stat, 4'd1);
    m_stat = 4'd1; W_stat = 4'd3; W_icode = 4'h3;
    #1 chk("adr_w_ctl", ctl, 6'b000011);
    tick();                                           // cycle 12, HALTED
    chk("halt_halted", halted, 1'b1);
    chk("halt_stat", cpu_stat, 4'd3);
    chk("halt_cycle", cycle_cnt, 12);
    chk("halt_adr_noretire", retired_cnt, 1);
    idle();
    E_icode = 4'h7; e_Cnd = 1'b0;
    #1 chk("halted_ctl", ctl, 6'b110011);
    repeat (3) tick();
    chk("halted_cycle_frozen", cycle_cnt, 12);
    chk("halted_mp_frozen", mispred_cnt, 1);
    chk("halted_terminal", halted, 1'b1);
    idle();

    // asynchronous reset out of HALTED
    #2 rst = 1'b1;
    #1;
    chk("arst_halted", halted, 1'b0);
    chk("arst_stat", cpu_stat, 4'd1);
    chk("arst_lu", loaduse_cnt, 0);
    @(negedge clk) rst = 1'b0;
    tick();                                           // cycle 1

    // reset mid-DRAIN
    m_stat = 4'd3;
    tick();                                           // cycle 2, DRAIN
    m_stat = 4'd1;
    tick();                                           // cycle 3, still DRAIN
    chk("drain_counts", cycle_cnt, 3);
    chk("drain_not_halted", halted, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("drain_rst_stat", cpu_stat, 4'd1);
    chk("drain_rst_cycle", cycle_cnt, 0);
    @(negedge clk) rst = 1'b0;
    tick();                                           // cycle 1

    // W_stat wins over m_stat; retiring HALT counted once
    m_stat = 4'd4; W_stat = 4'd2; W_icode = 4'h0;
    #1 chk("prio_ctl", ctl, 6'b000011);
    tick();                                           // cycle 2, HALTED
    chk("prio_stat", cpu_stat, 4'd2);
    chk("prio_halted", halted, 1'b1);
    tick();
    chk("halt_retire_once", retired_cnt, 1);
    idle();

    // counter wrap on the 4-bit instance
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (15) tick();
    chk("wrap_15", w_cycle_cnt, 4'd15);
    tick();
    chk("wrap_0", w_cycle_cnt, 4'd0);
    chk("wide_16", cycle_cnt, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_64.md
# pipe_ctrl_64

Pipeline control unit for the five-stage Y86-64 pipeline. It detects load-use, mispredicted-branch and `ret` hazards and drives the stall and bubble controls of the F, D, E, M and W pipeline registers. It also sequences processor status through a run/drain/halt state machine, supports a debug freeze, and keeps wrapping performance counters. The block sits beside the stage modules and is the only source of their stall and bubble inputs.

## Interface
- `CNT_W`, default 32: width of every performance counter.
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `D_icode` in 4: icode in the decode register.
- `d_srcA`, `d_srcB` in 4 each: decode source registers; 0xF means none.
- `E_icode`, `E_dstM` in 4 each: execute-register icode and memory destination.
- `e_Cnd` in 1: branch condition computed in execute.
- `M_icode` in 4: memory-register icode.
- `m_stat` in 4: status produced by the memory stage.
- `W_stat`, `W_icode` in 4 each: writeback-register status and icode.
- `dbg_freeze` in 1: hold the whole pipeline.
- `F_stall`, `D_stall`, `D_bubble`, `E_bubble`, `M_bubble`, `W_stall` out 1 each: pipeline register controls.
- `cpu_stat` out 4: architectural status.
- `halted` out 1: high in state HALTED.
- `cycle_cnt`, `retired_cnt`, `loaduse_cnt`, `mispred_cnt`, `ret_cnt` out CNT_W each: performance counters.

## Operation
- Status codes: AOK=1, HLT=2, ADR=3, INS=4.
- Icodes: HALT=0, NOP=1, JXX=7, CALL=8, RET=9, MRMOV=5, POPQ=B.
- Hazard terms, combinational:
  - `lu` = E_icode∈{MRMOV,POPQ} ∧ E_dstM≠0xF ∧ E_dstM∈{d_srcA,d_srcB}.
  - `mp` = E_icode=JXX ∧ ¬e_Cnd.
  - `rt` = RET∈{D_icode,E_icode,M_icode}.
  - `ex` = m_stat∈{HLT,ADR,INS} ∨ W_stat∈{HLT,ADR,INS}.
- Controls in state RUN with dbg_freeze=0:
  - F_stall = lu ∨ rt.
  - D_stall = lu.
  - D_bubble = mp ∨ (rt ∧ ¬lu).
  - E_bubble = mp ∨ lu.
  - M_bubble = ex.
  - W_stall = W_stat≠AOK.
- Stall and bubble on the same register: stall wins. D_bubble is already masked by lu; no other overlap exists.
- dbg_freeze=1 in RUN or DRAIN: all stalls high, all bubbles low, state and counters held.
- State machine (reset → RUN):
  - RUN → HALTED when W_stat≠AOK; cpu_stat ← W_stat.
  - RUN → DRAIN when m_stat≠AOK and W_stat=AOK.
  - DRAIN → HALTED when W_stat≠AOK; cpu_stat ← W_stat. Otherwise stay in DRAIN.
  - In DRAIN, hazard controls are as in RUN. M_bubble stays high whenever m_stat or W_stat is non-AOK.
  - HALTED is terminal until rst. All stalls are high, M_bubble=1, other bubbles low.
- W_stat has priority when m_stat and W_stat are both non-AOK in the same cycle.
- Counters increment only in RUN or DRAIN with dbg_freeze=0:
  - cycle_cnt: every cycle.
  - retired_cnt: W_icode≠NOP and W_stat∈{AOK,HLT}. A retiring HALT counts once, on its transition cycle.
  - loaduse_cnt: lu.
  - mispred_cnt: mp.
  - ret_cnt: rt ∧ ¬lu.
- Counters wrap modulo 2^CNT_W.

## Timing
- Hazard and control outputs are combinational from current-cycle inputs, with zero latency. Stage registers sample them on the next rising clk.
- State, cpu_stat, halted and counters are registered and update on rising clk.
- Reset values:
  - state RUN, cpu_stat=AOK (1), halted=0, all counters 0.
  - Controls then follow the combinational rules from the current inputs.
- rst asserted mid-operation, including in DRAIN or HALTED: outputs take reset values immediately (asynchronous). Operation resumes on the first rising clk after rst is released.
- halted and cpu_stat change one edge after W_stat becomes non-AOK.

## Structure
- Shared package `y86_pkg`: icode constants, stat constants, and the state enum {RUN, DRAIN, HALTED}. The decode/execute stages reuse it.
- Sub-module `y86_hazard_detect`: purely combinational; produces lu, mp, rt and ex.
- The top level holds the FSM, control muxing and counters.

## Test plan
- Load-use: E_icode=5, E_dstM=3, d_srcA=3 → F_stall=D_stall=E_bubble=1, D_bubble=0; loaduse_cnt +1 per cycle.
- Mispredict: E_icode=7, e_Cnd=0 → D_bubble=E_bubble=1, F_stall=0; mispred_cnt +1. With e_Cnd=1, all controls are 0.
- ret: D_icode=9 for one cycle, then E_icode=9, then M_icode=9 → F_stall=1 and D_bubble=1 for 3 cycles; ret_cnt=3.
- Combined ret in D and load-use: D_icode=9 with lu true → D_stall=1, D_bubble=0; ret_cnt unchanged that cycle.
- ADR exception: m_stat=3 for one cycle, then W_stat=3 → M_bubble=1, state DRAIN. Next edge: halted=1, cpu_stat=3, W_stall=1; counters frozen after that.
- Freeze, reset and wrap:
  - dbg_freeze=1 for 5 cycles → all stalls high and cycle_cnt unchanged.
  - rst pulse mid-DRAIN → immediate cpu_stat=1, halted=0.
  - CNT_W=4 → cycle_cnt wraps 15→0.
